// File: rtl/adc_frame_align.sv
// adc_frame_align: bit-slip word alignment downstream of deser_12.
// Hunts for the frame-lane pattern, then applies the same offset to every data lane.
module adc_frame_align #(
    parameter int             W             = 12,
    parameter int             N_CH          = 2,
    parameter logic [W-1:0]   FRAME_PATTERN = 12'hFC0,
    parameter int             SETTLE        = 4,
    parameter int             LOCK_COUNT    = 16,
    parameter int             LOSS_COUNT    = 4
) (
    input  logic              i_adc_clk_x2,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_in_valid,
    input  logic [W-1:0]      i_frame_in,
    input  logic [N_CH*W-1:0] i_data_in,
    input  logic              i_clr_lost,
    output logic              o_out_valid,
    output logic [N_CH*W-1:0] o_out_data,
    output logic              o_locked,
    output logic [3:0]        o_slip_offset,
    output logic              o_search_wrap,
    output logic              o_lock_lost
);

    localparam int CNT_MAX = (LOCK_COUNT > SETTLE) ? LOCK_COUNT : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int MW      = $clog2(LOSS_COUNT + 1);
    localparam logic [3:0] OFF_MAX = 4'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [MW-1:0]       r_miss;
    logic [3:0]          r_off;
    logic [W-1:0]        r_prev_frame;
    logic [N_CH*W-1:0]   r_prev_data;
    logic                r_out_valid;
    logic [N_CH*W-1:0]   r_out_data;
    logic                r_locked;
    logic                r_wrap;
    logic                r_lost;

    logic [W-1:0]        w_frame_aln;
    logic [N_CH*W-1:0]   w_data_aln;
    logic                w_match;

    // Top W bits of the {prev, cur} window after shifting out `off` bits.
    function automatic logic [W-1:0] f_align(
        input logic [W-1:0] prev,
        input logic [W-1:0] cur,
        input logic [3:0]   off
    );
        logic [2*W-1:0] win;
        win = {prev, cur} << off;
        return win[2*W-1 -: W];
    endfunction

    assign w_frame_aln = f_align(r_prev_frame, i_frame_in, r_off);
    assign w_match     = (w_frame_aln == FRAME_PATTERN);

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        assign w_data_aln[g*W +: W] =
            f_align(r_prev_data[g*W +: W], i_data_in[g*W +: W], r_off);
    end

    always_ff @(posedge i_adc_clk_x2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_frame <= '0;
            r_prev_data  <= '0;
        end else if (i_in_valid) begin
            r_prev_frame <= i_frame_in;
            r_prev_data  <= i_data_in;
        end
    end

    always_ff @(posedge i_adc_clk_x2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_miss      <= '0;
            r_off       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_locked    <= 1'b0;
            r_wrap      <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            // Clear is issued first so a same-cycle loss overrides it.
            if (i_clr_lost) r_lost <= 1'b0;
            if (!i_en) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_miss      <= '0;
                r_locked    <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= i_in_valid && (r_state == S_LOCKED);
                if (i_in_valid) begin
                    if (r_state == S_LOCKED) r_out_data <= w_data_aln;
                    unique case (r_state)
                        S_IDLE: begin
                            r_state <= S_SETTLE;
                            r_cnt   <= '0;
                        end
                        S_SETTLE: begin
                            if (r_cnt == CW'(SETTLE - 1)) begin
                                r_state <= S_CHECK;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                        S_CHECK: begin
                            if (r_cnt == CW'(LOCK_COUNT)) begin
                                r_state  <= S_LOCKED;
                                r_cnt    <= '0;
                                r_miss   <= '0;
                                r_locked <= 1'b1;
                            end else if (w_match) begin
                                r_cnt <= r_cnt + CW'(1);
                            end else begin
                                r_state <= S_SLIP;
                                r_cnt   <= '0;
                            end
                        end
                        S_SLIP: begin
                            if (r_off == OFF_MAX) begin
                                r_off  <= '0;
                                r_wrap <= 1'b1;
                            end else begin
                                r_off <= r_off + 4'd1;
                            end
                            r_state <= S_SETTLE;
                            r_cnt   <= '0;
                        end
                        S_LOCKED: begin
                            if (w_match) begin
                                r_miss <= '0;
                            end else if (r_miss == MW'(LOSS_COUNT - 1)) begin
                                r_state  <= S_SETTLE;
                                r_cnt    <= '0;
                                r_miss   <= '0;
                                r_locked <= 1'b0;
                                r_lost   <= 1'b1;
                            end else begin
                                r_miss <= r_miss + MW'(1);
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_locked      = r_locked;
    assign o_slip_offset = r_off;
    assign o_search_wrap = r_wrap;
    assign o_lock_lost   = r_lost;

endmodule

// File: tb/tb_adc_frame_align.sv
// tb_adc_frame_align: directed and random checks of adc_frame_align
// against a word-level reference model.
module tb_adc_frame_align;

    localparam int W          = 12;
    localparam int N_CH       = 2;
    localparam int SETTLE     = 4;
    localparam int LOCK_COUNT = 16;
    localparam int LOSS_COUNT = 4;
    localparam logic [11:0] PAT = 12'hFC0;

    localparam int P_IDLE   = 0;
    localparam int P_SETTLE = 1;
    localparam int P_CHECK  = 2;
    localparam int P_SLIP   = 3;
    localparam int P_LOCKED = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [11:0] frame_in;
    logic [23:0] data_in;
    logic        clr_lost;
    logic        o_out_valid;
    logic [23:0] o_out_data;
    logic        o_locked;
    logic [3:0]  o_slip_offset;
    logic        o_search_wrap;
    logic        o_lock_lost;

    int total = 0;
    int bad   = 0;
    int n_wrap;

    int          m_phase;
    int          m_n;
    int          m_miss;
    int          m_off;
    logic [11:0] m_pf;
    logic [23:0] m_pd;
    logic [23:0] m_od;
    logic        m_ov;
    logic        m_lk;
    logic        m_wrap;
    logic        m_lost;

    always #5 clk = ~clk;

    adc_frame_align dut (
        .i_adc_clk_x2  (clk),
        .i_rst_n       (rst_n),
        .i_en          (en),
        .i_in_valid    (in_valid),
        .i_frame_in    (frame_in),
        .i_data_in     (data_in),
        .i_clr_lost    (clr_lost),
        .o_out_valid   (o_out_valid),
        .o_out_data    (o_out_data),
        .o_locked      (o_locked),
        .o_slip_offset (o_slip_offset),
        .o_search_wrap (o_search_wrap),
        .o_lock_lost   (o_lock_lost)
    );

    function automatic logic [11:0] rotr(input logic [11:0] x, input int n);
        logic [23:0] d;
        d = {x, x} >> n;
        return d[11:0];
    endfunction

    // Word seen starting `off` bits into the prev/cur pair.
    function automatic logic [11:0] align(input logic [11:0] p,
                                          input logic [11:0] c,
                                          input int off);
        logic [23:0] d;
        d = {p, c} >> (W - off);
        return d[11:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_n     = 0;
        m_miss  = 0;
        m_off   = 0;
        m_pf    = '0;
        m_pd    = '0;
        m_od    = '0;
        m_ov    = 1'b0;
        m_lk    = 1'b0;
        m_wrap  = 1'b0;
        m_lost  = 1'b0;
    endtask

    task automatic model_step();
        logic [11:0] fa;
        fa     = align(m_pf, frame_in, m_off);
        m_wrap = 1'b0;
        if (clr_lost) m_lost = 1'b0;
        if (!en) begin
            m_phase = P_IDLE;
            m_n     = 0;
            m_miss  = 0;
            m_lk    = 1'b0;
            m_ov    = 1'b0;
        end else begin
            m_ov = in_valid && (m_phase == P_LOCKED);
            if (in_valid) begin
                if (m_phase == P_LOCKED)
                    for (int i = 0; i < N_CH; i++)
                        m_od[i*W +: W] = align(m_pd[i*W +: W], data_in[i*W +: W], m_off);
                case (m_phase)
                    P_IDLE: begin
                        m_phase = P_SETTLE;
                        m_n     = 0;
                    end
                    P_SETTLE: begin
                        m_n++;
                        if (m_n == SETTLE) begin
                            m_phase = P_CHECK;
                            m_n     = 0;
                        end
                    end
                    P_CHECK: begin
                        if (m_n == LOCK_COUNT) begin
                            m_phase = P_LOCKED;
                            m_lk    = 1'b1;
                            m_miss  = 0;
                        end else if (fa == PAT) begin
                            m_n++;
                        end else begin
                            m_phase = P_SLIP;
                            m_n     = 0;
                        end
                    end
                    P_SLIP: begin
                        m_off   = (m_off + 1) % W;
                        m_wrap  = (m_off == 0);
                        m_phase = P_SETTLE;
                        m_n     = 0;
                    end
                    default: begin
                        if (fa == PAT) begin
                            m_miss = 0;
                        end else begin
                            m_miss++;
                            if (m_miss == LOSS_COUNT) begin
                                m_phase = P_SETTLE;
                                m_n     = 0;
                                m_miss  = 0;
                                m_lk    = 1'b0;
                                m_lost  = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
        if (in_valid) begin
            m_pf = frame_in;
            m_pd = data_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", o_out_valid, m_ov);
        chk("out_data", o_out_data, m_od);
        chk("locked", o_locked, m_lk);
        chk("slip_offset", o_slip_offset, m_off);
        chk("search_wrap", o_search_wrap, m_wrap);
        chk("lock_lost", o_lock_lost, m_lost);
        if (o_search_wrap) n_wrap++;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        clr_lost = 1'b0;
        frame_in = '0;
        data_in  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int clocks;
        int words;
        int lk_seen;
        int rot;

        // Reset values
        do_reset();
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_out_data", o_out_data, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_offset", o_slip_offset, 0);
        chk("rst_wrap", o_search_wrap, 0);
        chk("rst_lost", o_lock_lost, 0);

        // Frame rotated right by 3 with constant data lanes
        en       = 1'b1;
        in_valid = 1'b1;
        frame_in = 12'h1F8;
        data_in  = {12'h0F0, 12'h957};
        n_wrap   = 0;
        clocks   = 0;
        while (!o_locked && clocks < 200) begin
            tick();
            clocks++;
        end
        chk("t1_lock_clocks", clocks, 3*(SETTLE+2) + SETTLE + LOCK_COUNT + 2);
        chk("t1_offset", o_slip_offset, 3);
        chk("t1_no_wrap", n_wrap, 0);

        repeat (4) begin
            tick();
            chk("t2_out_valid", o_out_valid, 1);
            chk("t2_out_data", o_out_data, {12'h780, 12'hABC});
        end

        // Three bad words: the first zero still completes a good window
        repeat (3) begin frame_in = 12'h000; tick(); end
        repeat (3) begin frame_in = 12'h1F8; tick(); end
        chk("t3_still_locked", o_locked, 1);
        chk("t3_no_lost", o_lock_lost, 0);

        // Four zeros plus the zero-to-pattern window give the fourth miss
        repeat (4) begin frame_in = 12'h000; tick(); end
        frame_in = 12'h1F8;
        tick();
        chk("t3_unlocked", o_locked, 0);
        chk("t3_lost", o_lock_lost, 1);
        chk("t3_loss_word_valid", o_out_valid, 1);
        chk("t3_offset_kept", o_slip_offset, 3);
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        chk("t3_lost_cleared", o_lock_lost, 0);

        // Pattern-free frame: endless search with periodic wrap
        do_reset();
        en       = 1'b1;
        in_valid = 1'b1;
        frame_in = 12'hAAA;
        n_wrap   = 0;
        lk_seen  = 0;
        repeat (150) begin
            tick();
            if (o_locked) lk_seen++;
        end
        chk("t4_wraps", n_wrap, (150 - 1) / (12 * (SETTLE + 2)));
        chk("t4_never_locked", lk_seen, 0);

        // Alternating in_valid with frame rotated right by 5
        do_reset();
        en       = 1'b1;
        frame_in = rotr(PAT, 5);
        words    = 0;
        clocks   = 0;
        while (!o_locked && clocks < 400) begin
            in_valid = (clocks % 2 == 0);
            if (in_valid) words++;
            tick();
            clocks++;
        end
        chk("t5_valid_words", words, 5*(SETTLE+2) + SETTLE + LOCK_COUNT + 2);
        chk("t5_offset", o_slip_offset, 5);

        // Asynchronous reset while checking at offset 7
        do_reset();
        en       = 1'b1;
        in_valid = 1'b1;
        frame_in = rotr(PAT, 7);
        clocks   = 0;
        while (o_slip_offset != 4'd7 && clocks < 200) begin
            tick();
            clocks++;
        end
        chk("t6_reach_off7", o_slip_offset, 7);
        repeat (SETTLE + 3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_offset", o_slip_offset, 0);
        chk("t6_rst_locked", o_locked, 0);
        chk("t6_rst_out_valid", o_out_valid, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        clocks = 0;
        while (!o_locked && clocks < 300) begin
            tick();
            clocks++;
        end
        chk("t6_relock", o_locked, 1);
        chk("t6_relock_off", o_slip_offset, 7);
        en = 1'b0;
        tick();
        chk("t6_en_off_locked", o_locked, 0);
        chk("t6_en_off_valid", o_out_valid, 0);
        chk("t6_en_off_offset", o_slip_offset, 7);

        // Random traffic against the model
        en  = 1'b1;
        rot = 0;
        for (int c = 0; c < 800; c++) begin
            if (c % 100 == 0) rot = $urandom_range(0, 11);
            frame_in = ($urandom_range(0, 39) == 0) ? 12'($urandom) : rotr(PAT, rot);
            data_in  = 24'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            clr_lost = ($urandom_range(0, 19) == 0);
            en       = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
